// File: rtl/full_adder_hs.sv
// 1-bit full adder whose sum path is two cascaded half-subtractor cells, with an
// optional registered copy of the result for pipelined users.
module full_adder_hs #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q,
  output logic valid_q
);

  // First half subtractor: difference of a and b. The borrow outputs of both
  // cells are not needed for carry, so they are not built.
  logic d1;
  // Second half subtractor: difference of d1 and carry-in.
  logic d2;

  // Sum path through the two cascaded half-subtractor differences.
  always_comb begin
    d1 = a ^ b;
    d2 = d1 ^ c;
    sum = d2;
  end

  // Carry is generated by a&b or propagated by c when exactly one of a/b is set.
  always_comb begin
    carry = (a & b) | (c & d1);
  end

  if (REG_OUT) begin : g_reg
    logic sum_reg;
    logic carry_reg;
    logic valid_reg;

    // Flopped copy of the combinational result; synchronous clear on rst.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_reg   <= 1'b0;
        carry_reg <= 1'b0;
        valid_reg <= 1'b0;
      end else begin
        sum_reg   <= sum;
        carry_reg <= carry;
        valid_reg <= 1'b1;
      end
    end

    assign sum_q   = sum_reg;
    assign carry_q = carry_reg;
    assign valid_q = valid_reg;
  end else begin : g_noreg
    assign sum_q   = 1'b0;
    assign carry_q = 1'b0;
    assign valid_q = 1'b0;
  end

endmodule

// File: tb/tb_full_adder_hs.sv
// Self-checking bench for full_adder_hs: arithmetic reference model plus
// hand-computed literal checks, with registered and unregistered builds side by side.
module tb_full_adder_hs;

  logic clk;
  logic rst;
  logic a, b, c;
  logic sum1, carry1, sum_q1, carry_q1, valid_q1;
  logic sum0, carry0, sum_q0, carry_q0, valid_q0;

  int n_vec;
  int n_err;

  // Reference model state for the registered outputs.
  logic m_sq, m_cq, m_v;
  bit   m_known;

  full_adder_hs #(.REG_OUT(1'b1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .sum    (sum1),
    .carry  (carry1),
    .sum_q  (sum_q1),
    .carry_q(carry_q1),
    .valid_q(valid_q1)
  );

  full_adder_hs #(.REG_OUT(1'b0)) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .sum    (sum0),
    .carry  (carry0),
    .sum_q  (sum_q0),
    .carry_q(carry_q0),
    .valid_q(valid_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic model_sum(input logic x, input logic y, input logic z);
    int t;
    t = int'(x) + int'(y) + int'(z);
    return logic'(t % 2);
  endfunction

  function automatic logic model_carry(input logic x, input logic y, input logic z);
    int t;
    t = int'(x) + int'(y) + int'(z);
    return logic'(t / 2);
  endfunction

  // Model of the registered stage: what the flops must hold after each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_sq = 1'b0;
      m_cq = 1'b0;
      m_v  = 1'b0;
    end else begin
      m_sq = model_sum(a, b, c);
      m_cq = model_carry(a, b, c);
      m_v  = 1'b1;
    end
    m_known = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_sum", sum1, model_sum(a, b, c));
    chk("cyc_carry", carry1, model_carry(a, b, c));
    chk("cyc_sum_r0", sum0, model_sum(a, b, c));
    chk("cyc_carry_r0", carry0, model_carry(a, b, c));
    chk("cyc_regs_r0", sum_q0 | carry_q0 | valid_q0, 1'b0);
    if (m_known) begin
      chk("cyc_sum_q", sum_q1, m_sq);
      chk("cyc_carry_q", carry_q1, m_cq);
      chk("cyc_valid_q", valid_q1, m_v);
    end
  end

  task automatic drive(input logic [2:0] v);
    @(negedge clk);
    #1;
    {a, b, c} = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Expected {sum,carry} for {a,b,c} = 0..7, from the truth table.
  logic [1:0] lit_tab [8];

  initial begin
    lit_tab[0] = 2'b00; lit_tab[1] = 2'b10; lit_tab[2] = 2'b10; lit_tab[3] = 2'b01;
    lit_tab[4] = 2'b10; lit_tab[5] = 2'b01; lit_tab[6] = 2'b01; lit_tab[7] = 2'b11;
    n_vec   = 0;
    n_err   = 0;
    m_known = 1'b0;
    rst     = 1'b1;
    {a, b, c} = 3'b000;

    // Exhaustive combinational sweep, offset from the clock edges.
    #2;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      chk("sweep_sum", sum1, lit_tab[i][1]);
      chk("sweep_carry", carry1, lit_tab[i][0]);
      chk("sweep_sum_r0", sum0, lit_tab[i][1]);
      chk("sweep_carry_r0", carry0, lit_tab[i][0]);
      chk("sweep_regs_r0", sum_q0 | carry_q0 | valid_q0, 1'b0);
      #9;
    end

    // Reset held with 111 on the inputs.
    drive(3'b111);
    after_edge();
    after_edge();
    chk("rst_sum", sum1, 1'b1);
    chk("rst_carry", carry1, 1'b1);
    chk("rst_sum_q", sum_q1, 1'b0);
    chk("rst_carry_q", carry_q1, 1'b0);
    chk("rst_valid_q", valid_q1, 1'b0);

    // Registered latency: nothing moves before the edge.
    drive(3'b011);
    rst = 1'b0;
    #1;
    chk("lat_pre_carry_q", carry_q1, 1'b0);
    chk("lat_pre_valid_q", valid_q1, 1'b0);
    after_edge();
    chk("lat_sum_q", sum_q1, 1'b0);
    chk("lat_carry_q", carry_q1, 1'b1);
    chk("lat_valid_q", valid_q1, 1'b1);

    // Back-to-back input changes.
    drive(3'b110);
    after_edge();
    chk("b2b0_sum_q", sum_q1, 1'b0);
    chk("b2b0_carry_q", carry_q1, 1'b1);
    drive(3'b001);
    after_edge();
    chk("b2b1_sum_q", sum_q1, 1'b1);
    chk("b2b1_carry_q", carry_q1, 1'b0);
    drive(3'b111);
    after_edge();
    chk("b2b2_sum_q", sum_q1, 1'b1);
    chk("b2b2_carry_q", carry_q1, 1'b1);

    // Mid-stream reset for a single edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    after_edge();
    chk("mid_sum_q", sum_q1, 1'b0);
    chk("mid_carry_q", carry_q1, 1'b0);
    chk("mid_valid_q", valid_q1, 1'b0);
    chk("mid_sum", sum1, 1'b1);
    chk("mid_carry", carry1, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    after_edge();
    chk("post_sum_q", sum_q1, 1'b1);
    chk("post_carry_q", carry_q1, 1'b1);
    chk("post_valid_q", valid_q1, 1'b1);

    // Randomized traffic with occasional resets; the negedge process checks it.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      {a, b, c} = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder_hs.md
Name: full_adder_hs

Overview:
- 1-bit full adder whose sum path is built from half-subtractor cells.
- Leaf arithmetic cell for the RTL exercise set and for ripple-chain reuse.
- Combinational sum/carry outputs are always live.
- A registered copy of the result on a single clock domain gives pipelined users a flopped version.

Parameters:
- REG_OUT, 1, enables the registered output stage. When 0, sum_q/carry_q are tied to 0 and valid_q is tied to 0.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  reset, synchronous, active-high.
- a  input  1  addend bit A.
- b  input  1  addend bit B.
- c  input  1  carry-in.
- sum  output  1  combinational sum = a ^ b ^ c.
- carry  output  1  combinational carry-out = majority(a, b, c).
- sum_q  output  1  registered sum.
- carry_q  output  1  registered carry.
- valid_q  output  1  high once a post-reset sample has been captured into sum_q/carry_q.

Interface:
- One clock (clk). Reset rst is synchronous and active-high.
- All flops update only on the rising edge of clk.

Behaviour:
- Combinational path, zero latency, independent of clk/rst:
  - sum = a XOR b XOR c.
  - carry = (a AND b) OR (c AND (a XOR b)).
  - The path must settle within the same simulation timestep as an input change.
- Internal structure of the sum path is two cascaded half subtractors:
  - HS1(a, b) gives d1 = a^b and bo1 = ~a&b.
  - HS2(d1, c) gives d2 = d1^c.
  - sum = d2.
- Internal structure of the carry path:
  - carry is formed from a&b and c&d1.
  - The borrow outputs are unused for carry.
  - Any realisation with an identical truth table is acceptable.
- Truth table, (a b c) -> (sum carry):
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- Registered path, when REG_OUT=1:
  - On a rising clk edge with rst=1: sum_q=0, carry_q=0, valid_q=0.
  - On a rising clk edge with rst=0: sum_q<=sum, carry_q<=carry, valid_q<=1.
  - Latency is 1 clk cycle from the input sampled at an edge to the registered outputs.
- Reset values are 0 for all registered outputs.
- Combinational outputs ignore rst. They reflect the inputs even while reset is held.
- Reset asserted mid-operation clears the registered outputs on the next rising edge only. There is no asynchronous clear.
- Before the first clock edge, registered outputs are X until a reset edge occurs. Benches must apply rst for at least 1 cycle.
- X or Z on any input propagates to sum/carry and is not masked.
- No internal state other than the three output flops.

Test Plan:
- Exhaustive sweep, combinational: drive {a,b,c}=0..7, 10 ns per vector, 80 ns total. Expected sum/carry sequence: 00,10,10,01,10,01,01,11. Check each vector 1 ns after it is applied.
- Reset behaviour: hold rst=1 for 2 edges with a=b=c=1. Expect sum=1, carry=1 combinationally. Expect sum_q=0, carry_q=0, valid_q=0 after the edges.
- Registered latency: release rst, then apply 011 before edge N. Expect sum_q=0, carry_q=1, valid_q=1 after edge N. The outputs must not change before that edge.
- Back-to-back changes: apply 110, 001, 111 on consecutive cycles. Expect registered (sum_q, carry_q) of 01, 10, 11 on the following three edges.
- Mid-stream reset: apply 111 and clock, giving sum_q/carry_q=11. Assert rst for one edge. Expect 00 and valid_q=0 on that edge while combinational sum/carry stay 11. Deassert rst and expect 11 again on the next edge.
- REG_OUT=0 build: run the exhaustive sweep. Combinational results must be unchanged, and sum_q, carry_q, valid_q must stay 0 throughout.
